// File: rtl/lx32_branch_pkg.sv
// Shared branch types: RV32I branch conditions, BHT counter states and
// saturating counter helpers.
package lx32_branch_pkg;

    // Encodings follow the RV32I funct3 field of the branch instructions.
    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } branch_op_e;

    typedef enum logic [1:0] {
        BHT_SNT = 2'b00,
        BHT_WNT = 2'b01,
        BHT_WT  = 2'b10,
        BHT_ST  = 2'b11
    } bht_state_e;

    localparam bht_state_e BHT_RESET = BHT_WNT;

    function automatic bht_state_e bht_inc(input bht_state_e s);
        return (s == BHT_ST) ? BHT_ST : bht_state_e'(s + 2'd1);
    endfunction

    function automatic bht_state_e bht_dec(input bht_state_e s);
        return (s == BHT_SNT) ? BHT_SNT : bht_state_e'(s - 2'd1);
    endfunction

endpackage

// File: rtl/bht_array.sv
// Direct-mapped table of 2-bit saturating counters with one read port and
// one read-modify-write update port. Reads return the pre-update value.
module bht_array
    import lx32_branch_pkg::*;
#(
    parameter int unsigned ENTRIES = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic [$clog2(ENTRIES)-1:0] rd_idx,
    output bht_state_e                 rd_state,
    input  logic                       wr_en,
    input  logic [$clog2(ENTRIES)-1:0] wr_idx,
    input  logic                       wr_taken
);

    bht_state_e mem_q [ENTRIES];
    bht_state_e wr_state_d;

    // Read port: no bypass from the write port.
    assign rd_state = mem_q[rd_idx];

    // Next counter value for the entry being trained.
    always_comb begin
        wr_state_d = wr_taken ? bht_inc(mem_q[wr_idx]) : bht_dec(mem_q[wr_idx]);
    end

    // Storage: clear has priority over a same-cycle update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= BHT_RESET;
            end
        end else if (clear) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= BHT_RESET;
            end
        end else if (wr_en) begin
            mem_q[wr_idx] <= wr_state_d;
        end
    end

endmodule

// File: rtl/branch_unit.sv
// Combinational RV32I branch comparator; unknown conditions resolve not taken.
module branch_unit
    import lx32_branch_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             is_branch,
    input  branch_op_e       branch_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             branch_taken
);

    logic cond;

    // Evaluate the selected condition and qualify with is_branch.
    always_comb begin
        cond = 1'b0;
        unique case (branch_op)
            BR_EQ:   cond = (src_a == src_b);
            BR_NE:   cond = (src_a != src_b);
            BR_LT:   cond = ($signed(src_a) <  $signed(src_b));
            BR_GE:   cond = ($signed(src_a) >= $signed(src_b));
            BR_LTU:  cond = (src_a <  src_b);
            BR_GEU:  cond = (src_a >= src_b);
            default: cond = 1'b0;
        endcase
        branch_taken = is_branch & cond;
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predictor/resolver: BHT lookup at fetch, condition resolution at
// EX, registered redirect and saturating statistics.
module branch_predict_unit
    import lx32_branch_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned STAT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  pred_pc,
    output logic              pred_taken,
    input  logic              res_valid,
    input  logic              is_branch,
    input  branch_op_e        branch_op,
    input  logic [WIDTH-1:0]  src_a,
    input  logic [WIDTH-1:0]  src_b,
    input  logic [WIDTH-1:0]  res_pc,
    input  logic [WIDTH-1:0]  res_target,
    input  logic              res_pred_taken,
    input  logic              flush,
    input  logic              bht_clear,
    output logic              out_valid,
    output logic              branch_taken,
    output logic              mispredict,
    output logic [WIDTH-1:0]  redirect_pc,
    output logic [STAT_W-1:0] branch_count,
    output logic [STAT_W-1:0] mispredict_count
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    logic              accept;
    logic              outcome;
    logic              mis;
    bht_state_e        pred_state;
    logic              unused_pc_bits;

    logic              out_valid_q, out_valid_d;
    logic              taken_q,     taken_d;
    logic              mis_q,       mis_d;
    logic [WIDTH-1:0]  redirect_q,  redirect_d;
    logic [STAT_W-1:0] bcnt_q,      bcnt_d;
    logic [STAT_W-1:0] mcnt_q,      mcnt_d;

    assign accept = res_valid & is_branch & ~flush;
    assign mis    = outcome ^ res_pred_taken;

    // Only the index bits of the PCs select a table entry.
    assign unused_pc_bits = ^{pred_pc[WIDTH-1:IDX_W+2], pred_pc[1:0]};

    branch_unit #(
        .WIDTH (WIDTH)
    ) u_branch_unit (
        .is_branch    (accept),
        .branch_op    (branch_op),
        .src_a        (src_a),
        .src_b        (src_b),
        .branch_taken (outcome)
    );

    bht_array #(
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (bht_clear),
        .rd_idx   (pred_pc[IDX_W+1:2]),
        .rd_state (pred_state),
        .wr_en    (accept),
        .wr_idx   (res_pc[IDX_W+1:2]),
        .wr_taken (outcome)
    );

    assign pred_taken = pred_state[1];

    // Next-state for resolution outputs and saturating statistics.
    always_comb begin
        out_valid_d = accept;
        taken_d     = taken_q;
        mis_d       = mis_q;
        redirect_d  = redirect_q;
        bcnt_d      = bcnt_q;
        mcnt_d      = mcnt_q;
        if (accept) begin
            taken_d    = outcome;
            mis_d      = mis;
            redirect_d = outcome ? res_target : res_pc + WIDTH'(4);
            if (bcnt_q != '1) begin
                bcnt_d = bcnt_q + STAT_W'(1);
            end
            if (mis && (mcnt_q != '1)) begin
                mcnt_d = mcnt_q + STAT_W'(1);
            end
        end
    end

    // Output and statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            taken_q     <= 1'b0;
            mis_q       <= 1'b0;
            redirect_q  <= '0;
            bcnt_q      <= '0;
            mcnt_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            taken_q     <= taken_d;
            mis_q       <= mis_d;
            redirect_q  <= redirect_d;
            bcnt_q      <= bcnt_d;
            mcnt_q      <= mcnt_d;
        end
    end

    assign out_valid        = out_valid_q;
    assign branch_taken     = taken_q;
    assign mispredict       = mis_q;
    assign redirect_pc      = redirect_q;
    assign branch_count     = bcnt_q;
    assign mispredict_count = mcnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;
    import lx32_branch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        res_valid;
    logic        is_branch;
    branch_op_e  branch_op;
    logic [31:0] src_a, src_b, res_pc, res_target;
    logic        res_pred_taken, flush, bht_clear;
    logic        out_valid, branch_taken, mispredict;
    logic [31:0] redirect_pc, branch_count, mispredict_count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state
    int          m_bht [64];
    logic        m_valid, m_taken, m_mis;
    logic [31:0] m_red, m_bc, m_mc;

    branch_predict_unit #(
        .WIDTH       (32),
        .BHT_ENTRIES (64),
        .STAT_W      (32)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pred_pc          (pred_pc),
        .pred_taken       (pred_taken),
        .res_valid        (res_valid),
        .is_branch        (is_branch),
        .branch_op        (branch_op),
        .src_a            (src_a),
        .src_b            (src_b),
        .res_pc           (res_pc),
        .res_target       (res_target),
        .res_pred_taken   (res_pred_taken),
        .flush            (flush),
        .bht_clear        (bht_clear),
        .out_valid        (out_valid),
        .branch_taken     (branch_taken),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic ref_outcome(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int signed sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return sa < sb;
            3'd5:    return sa >= sb;
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_bht[i] = 1;
        m_valid = 0; m_taken = 0; m_mis = 0; m_red = '0; m_bc = '0; m_mc = '0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_valid"}, {31'b0, out_valid}, {31'b0, m_valid});
        check({tag, "_taken"}, {31'b0, branch_taken}, {31'b0, m_taken});
        check({tag, "_mis"},   {31'b0, mispredict}, {31'b0, m_mis});
        check({tag, "_red"},   redirect_pc, m_red);
        check({tag, "_bc"},    branch_count, m_bc);
        check({tag, "_mc"},    mispredict_count, m_mc);
    endtask

    // One cycle: inputs already driven; check prediction, clock, check outputs.
    task automatic step(input string tag);
        logic acc, oc;
        int   idx;
        @(negedge clk);
        check({tag, "_pred"}, {31'b0, pred_taken}, {31'b0, m_bht[pred_pc[7:2]] >= 2});
        acc = res_valid & is_branch & ~flush;
        oc  = ref_outcome(branch_op, src_a, src_b);
        @(posedge clk);
        #1;
        m_valid = acc;
        if (acc) begin
            idx = int'(res_pc[7:2]);
            if (oc) begin
                if (m_bht[idx] < 3) m_bht[idx]++;
            end else begin
                if (m_bht[idx] > 0) m_bht[idx]--;
            end
            m_taken = oc;
            m_mis   = oc ^ res_pred_taken;
            m_red   = oc ? res_target : res_pc + 32'd4;
            if (m_bc != 32'hFFFF_FFFF) m_bc++;
            if (m_mis && m_mc != 32'hFFFF_FFFF) m_mc++;
        end
        if (bht_clear) for (int i = 0; i < 64; i++) m_bht[i] = 1;
        check_outputs(tag);
    endtask

    task automatic drive(input logic v, input logic isb, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] tgt,
                         input logic pr, input logic fl, input logic clr,
                         input logic [31:0] ppc);
        res_valid = v; is_branch = isb; branch_op = branch_op_e'(op);
        src_a = a; src_b = b; res_pc = pc; res_target = tgt;
        res_pred_taken = pr; flush = fl; bht_clear = clr; pred_pc = ppc;
    endtask

    task automatic idle(input logic [31:0] ppc);
        drive(0, 0, 3'd0, '0, '0, '0, '0, 0, 0, 0, ppc);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst");
        for (int unsigned p = 0; p <= 32'hFC; p += 4) begin
            pred_pc = p;
            #1;
            check("rst_pred", {31'b0, pred_taken}, 32'd0);
        end
        idle('0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle('0);
        model_reset();
        do_reset();

        // BEQ equal, predicted not taken -> mispredict to target
        drive(1, 1, 3'd0, 32'd5, 32'd5, 32'h100, 32'h80, 0, 0, 0, 32'h0);
        step("beq");
        check("beq_red_abs", redirect_pc, 32'h80);
        check("beq_bc_abs", branch_count, 32'd1);
        idle(32'h100); step("pred100");
        idle(32'h200); step("pred200");

        // Three taken BLTU then one not taken, all predicted taken
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 3'd6, 32'd1, 32'd2, 32'h40, 32'h400, 1, 0, 0, 32'h40);
            step("bltu_t");
        end
        drive(1, 1, 3'd6, 32'd3, 32'd2, 32'h40, 32'h400, 1, 0, 0, 32'h40);
        step("bltu_nt");
        check("bltu_nt_mis_abs", {31'b0, mispredict}, 32'd1);
        idle(32'h40); step("pred40");

        // Signed vs unsigned GE
        drive(1, 1, 3'd5, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h500, 0, 0, 0, 32'h0);
        step("bge");
        drive(1, 1, 3'd7, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h500, 0, 0, 0, 32'h0);
        step("bgeu");
        check("bgeu_red_abs", redirect_pc, 32'h500);

        // Fall-through wraps past the top of the address space
        drive(1, 1, 3'd0, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'h10, 1, 0, 0, 32'hFFFF_FFFC);
        step("wrap");
        check("wrap_red_abs", redirect_pc, 32'h0);

        // Flush kills a valid branch
        drive(1, 1, 3'd1, 32'd1, 32'd2, 32'h40, 32'h44, 0, 1, 0, 32'h40);
        step("flush");
        idle(32'h40); step("after_flush");

        // Clear beats an update to a WT entry
        drive(1, 1, 3'd0, 32'd7, 32'd7, 32'h40, 32'h44, 1, 0, 1, 32'h40);
        step("clr");
        idle(32'h40); step("after_clr");
        check("clr_pred_abs", {31'b0, pred_taken}, 32'd0);

        // Randomized traffic with one mid-run reset
        for (int unsigned i = 0; i < 3000; i++) begin
            logic [31:0] a, b;
            if (i == 1500) do_reset();
            a = $urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 4) - 2;
            b = $urandom_range(0, 2) == 0 ? a : ($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 4) - 2);
            drive($urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0,
                  3'($urandom_range(0, 7)), a, b,
                  {22'($urandom_range(0, 3) == 0 ? $urandom : 0), 8'($urandom_range(0, 255)) & 8'hFC, 2'b00} |
                      ($urandom_range(0, 50) == 0 ? 32'hFFFF_FFFC : 32'h0),
                  $urandom, 1'($urandom), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 99) == 0, {$urandom} & 32'hFFFF_FFFC);
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
